// File: rtl/mem_seq_ctrl.sv
// Memory-access sequencer: latches one CPU read/write, drives RAM strobes for WAIT_STATES+1 cycles, pulses done.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range addresses skip the RAM access and complete with err=1.
module mem_seq_ctrl #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_DEPTH   = 512,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SETUP    = 2'd1;
    localparam logic [1:0] S_ACCESS   = 2'd2;
    localparam logic [1:0] S_COMPLETE = 2'd3;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              we_q, we_d;
    logic              oob_q, oob_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d;
    logic [DATA_W-1:0] rdata_d;
    logic              rd_d, wr_d, busy_d, done_d, err_d;
    logic              oob_c;

    // Full-width compare; constant-masked away when the bounds check is disabled
    assign oob_c = BOUNDS_EN && (addr >= 32'(MEM_DEPTH));

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we_d    = we_q;
        oob_d   = oob_q;
        addr_d  = mem_addr;
        din_d   = mem_din;
        rdata_d = rdata;

        case (state)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr[ADDR_W-1:0];
                    if (we) begin
                        din_d = wdata;
                    end
                    we_d    = we;
                    oob_d   = oob_c;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (oob_q) begin
                    state_d = S_COMPLETE;
                end else begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            S_ACCESS: begin
                if (cnt == '0) begin
                    state_d = S_COMPLETE;
                    if (!we_q) begin
                        rdata_d = mem_dout;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_d   = (state_d == S_ACCESS) && !we_d;
        wr_d   = (state_d == S_ACCESS) && we_d;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_COMPLETE);
        err_d  = done_d && oob_d;
    end

    // State and output registers; clr drops strobes immediately
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            oob_q     <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            we_q      <= we_d;
            oob_q     <= oob_d;
            mem_addr  <= addr_d;
            mem_din   <= din_d;
            rdata     <= rdata_d;
            mem_read  <= rd_d;
            mem_write <= wr_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: two instances (WAIT_STATES=2 and 0) share stimulus, each with its own RAM model.
module tb_mem_seq_ctrl;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 512;

    logic              clk = 1'b0;
    logic              clr;
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;

    logic [DATA_W-1:0] dout  [2];
    logic [ADDR_W-1:0] ma    [2];
    logic [DATA_W-1:0] din   [2];
    logic              rd    [2];
    logic              wr    [2];
    logic [DATA_W-1:0] rdat  [2];
    logic              busy  [2];
    logic              done  [2];
    logic              err   [2];

    logic [DATA_W-1:0] ram0    [DEPTH];
    logic [DATA_W-1:0] ram1    [DEPTH];
    logic [DATA_W-1:0] mem_ref [DEPTH];
    logic [DATA_W-1:0] last_din;
    logic [DATA_W-1:0] last_rdata;

    int checks = 0;
    int errors = 0;
    int tn     = 0;

    always #5 clk = ~clk;

    mem_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .mem_dout(dout[0]), .mem_addr(ma[0]), .mem_din(din[0]), .mem_read(rd[0]),
        .mem_write(wr[0]), .rdata(rdat[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    mem_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .mem_dout(dout[1]), .mem_addr(ma[1]), .mem_din(din[1]), .mem_read(rd[1]),
        .mem_write(wr[1]), .rdata(rdat[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // Asynchronous-read RAM models, written on the clock edge while mem_write is high
    assign dout[0] = ram0[ma[0]];
    assign dout[1] = ram1[ma[1]];

    always @(posedge clk) begin
        if (wr[0]) ram0[ma[0]] <= din[0];
        if (wr[1]) ram1[ma[1]] <= din[1];
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic is_oob(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return a >= 32'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access, checked cycle by cycle from a timeline derived from the wait-state count
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic              oob;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       exp_din, new_rdata;
        int                ws, dk;
        string             p;
        oob       = is_oob(a);
        idx       = a[ADDR_W-1:0];
        exp_din   = w ? d : last_din;
        new_rdata = (!w && !oob) ? mem_ref[idx] : last_rdata;
        tn++;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req   = 1'b0;
                we    = 1'($urandom);
                addr  = $urandom;
                wdata = $urandom;
            end
            for (int i = 0; i < 2; i++) begin
                ws = ws_of(i);
                dk = oob ? 1 : 2 + ws;
                p  = $sformatf("t%0d_i%0d_k%0d", tn, i, k);
                check({p, "_busy"},  32'(busy[i]),  32'(k <= dk));
                check({p, "_done"},  32'(done[i]),  32'(k == dk));
                check({p, "_err"},   32'(err[i]),   32'((k == dk) && oob));
                check({p, "_rd"},    32'(rd[i]),    32'(!oob && !w && k >= 1 && k <= 1 + ws));
                check({p, "_wr"},    32'(wr[i]),    32'(!oob && w && k >= 1 && k <= 1 + ws));
                check({p, "_maddr"}, 32'(ma[i]),    32'(idx));
                check({p, "_mdin"},  din[i],        exp_din);
                check({p, "_rdata"}, rdat[i],       (k >= dk) ? new_rdata : last_rdata);
            end
        end
        last_din   = exp_din;
        last_rdata = new_rdata;
        if (w && !oob) mem_ref[idx] = d;
    endtask

    initial begin
        int          dn [2][2];
        int          nd [2];
        logic [31:0] a, d, b;
        logic        w, idle;

        for (int j = 0; j < int'(DEPTH); j++) begin
            ram0[j] = '0; ram1[j] = '0; mem_ref[j] = '0;
        end
        last_din = '0; last_rdata = '0;
        clr = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_i%0d_busy", i),  32'(busy[i]), 32'd0);
            check($sformatf("rst_i%0d_done", i),  32'(done[i]), 32'd0);
            check($sformatf("rst_i%0d_err", i),   32'(err[i]),  32'd0);
            check($sformatf("rst_i%0d_strb", i),  32'({rd[i], wr[i]}), 32'd0);
            check($sformatf("rst_i%0d_maddr", i), 32'(ma[i]),   32'd0);
            check($sformatf("rst_i%0d_rdata", i), rdat[i],      32'd0);
        end
        clr = 1'b1;
        @(negedge clk);

        run_txn(1'b1, 32'h0000_0005, 32'hDEAD_BEEF);
        run_txn(1'b0, 32'h0000_0005, 32'h0);
        run_txn(1'b1, 32'h0000_0200, 32'h1234_5678);
        run_txn(1'b0, 32'h0000_0200, 32'h0);
        run_txn(1'b0, 32'h0000_0000, 32'h0);
        run_txn(1'b1, 32'h0000_01FF, 32'hA5A5_5A5A);
        run_txn(1'b0, 32'h0000_01FF, 32'h0);

        for (int r = 0; r < 24; r++) begin
            w = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31));
            d = $urandom;
            run_txn(w, a, d);
        end

        // Held req: back-to-back reads, addr changes while busy only matter at the next accept
        b = 32'($urandom_range(32, 511));
        req = 1'b1; we = 1'b0; addr = 32'h0000_0005;
        nd[0] = 0; nd[1] = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) addr = b;
            for (int i = 0; i < 2; i++) begin
                if (done[i] && nd[i] < 2) begin
                    check($sformatf("held_i%0d_n%0d_maddr", i, nd[i]), 32'(ma[i]),
                          (nd[i] == 0) ? 32'd5 : 32'(b[ADDR_W-1:0]));
                    check($sformatf("held_i%0d_n%0d_rdata", i, nd[i]), rdat[i],
                          (nd[i] == 0) ? mem_ref[5] : mem_ref[b[ADDR_W-1:0]]);
                    dn[i][nd[i]] = c;
                    nd[i]++;
                end
            end
        end
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("held_i%0d_ndone", i), 32'(nd[i]), 32'd2);
            if (nd[i] == 2)
                check($sformatf("held_i%0d_spacing", i), 32'(dn[i][1] - dn[i][0]), 32'(ws_of(i) + 4));
        end
        idle = 1'b0;
        for (int c = 0; c < 20 && !idle; c++) begin
            @(negedge clk);
            idle = !busy[0] && !busy[1];
        end
        check("held_drain_idle", 32'(idle), 32'd1);
        last_rdata = mem_ref[b[ADDR_W-1:0]];
        @(negedge clk);

        // Reset in the middle of a write: WS=2 instance is in ACCESS with mem_write high
        req = 1'b1; we = 1'b1; addr = 32'h0000_0007; wdata = 32'hCAFE_F00D;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_wr", 32'(wr[0]), 32'd1);
        #2 clr = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_i%0d_wr", i),    32'(wr[i]),   32'd0);
            check($sformatf("abort_i%0d_busy", i),  32'(busy[i]), 32'd0);
            check($sformatf("abort_i%0d_done", i),  32'(done[i]), 32'd0);
            check($sformatf("abort_i%0d_rdata", i), rdat[i],      32'd0);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("post_rst_i%0d_idle", i), 32'(busy[i]), 32'd0);
        // Both instances had at least one write beat land on address 7 before the abort
        mem_ref[7] = 32'hCAFE_F00D;
        last_din   = '0;
        last_rdata = '0;

        run_txn(1'b0, 32'h0000_0005, 32'h0);
        run_txn(1'b0, 32'h0000_0007, 32'h0);
        run_txn(1'b1, 32'h0000_0003, 32'h0BAD_CAFE);
        run_txn(1'b0, 32'h0000_0003, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Strobes must never overlap on either instance
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr) check($sformatf("excl_i%0d", i), 32'(rd[i] && wr[i]), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
